// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-to-1 cache-bus arbiter (round-robin or fixed priority) with watchdog and abort detection.
// Defining CBUS_ARB_BYPASS_EN grants an idle request in the same cycle instead of one cycle later.
package common;
    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;
endpackage

module cbus_rr_arbiter
    import common::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 1024,
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout,
    output logic             abort
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
    logic             abort_q, abort_d;
    logic [IDX_W-1:0] sel, cur;
    logic             any_valid, owned, wd_hit, cur_valid;
    logic [WD_W-1:0]  wd_inc;
    int               cand;

    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // Scan backwards so the earliest candidate in priority order is the one left in sel.
    always_comb begin
        sel = '0;
        any_valid = 1'b0;
        cand = 0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            cand = (RR_MODE != 0) ? int'(rr_ptr_q) + k : k;
            cand = (cand >= NUM_INPUTS) ? cand - NUM_INPUTS : cand;
            if (ireqs[IDX_W'(cand)].valid) begin
                sel = IDX_W'(cand);
                any_valid = 1'b1;
            end
        end
    end

`ifdef CBUS_ARB_BYPASS_EN
    assign owned = (state_q == BUSY) || any_valid;
`else
    assign owned = (state_q == BUSY);
`endif
    assign cur = (state_q == BUSY) ? idx_q : sel;
    assign cur_valid = ireqs[cur].valid;
    // wd_cnt_q is held at zero in IDLE, so a bypass cycle counts as the first watched cycle.
    assign wd_hit = (TIMEOUT != 0) && !oresp.ready && (wd_cnt_q == WD_LIM);
    assign wd_inc = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rr_ptr_d  = rr_ptr_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b0;
        abort_d   = 1'b0;
        if (owned) begin
            if (oresp.last || !cur_valid || wd_hit) begin
                state_d   = IDLE;
                idx_d     = '0;
                wd_cnt_d  = '0;
                rr_ptr_d  = (RR_MODE != 0) ? nxt(cur) : '0;
                abort_d   = !oresp.last && !cur_valid;
                timeout_d = !oresp.last && cur_valid && wd_hit;
            end else begin
                state_d  = BUSY;
                idx_d    = cur;
                wd_cnt_d = (TIMEOUT == 0 || oresp.ready) ? '0 : wd_inc;
            end
        end else if (any_valid) begin
            state_d  = BUSY;
            idx_d    = sel;
            wd_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rr_ptr_q  <= '0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rr_ptr_q  <= rr_ptr_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_INPUTS; i++) iresps[i] = '0;
        if (owned) begin
            oreq = ireqs[cur];
            iresps[cur] = oresp;
        end
    end

    assign grant_valid = owned;
    assign grant_idx   = owned ? cur : '0;
    assign timeout     = timeout_q;
    assign abort       = abort_q;
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: directed bench for cbus_rr_arbiter, one round-robin and one fixed-priority instance.
module tb_cbus_rr_arbiter;
    import common::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    cbus_req_t  ireqs [4];
    cbus_resp_t oresp;
    cbus_resp_t iresps_rr [4];
    cbus_resp_t iresps_fp [4];
    cbus_req_t  oreq_rr, oreq_fp;
    logic       gv_rr, gv_fp, to_rr, to_fp, ab_rr, ab_fp;
    logic [1:0] gi_rr, gi_fp;
    int         tests = 0;
    int         fails = 0;
    int         rr_order [6] = '{0, 1, 3, 0, 1, 3};

    always #5 clk = ~clk;

    cbus_rr_arbiter #(.NUM_INPUTS(4), .RR_MODE(1), .TIMEOUT(8)) dut_rr (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps_rr), .oreq(oreq_rr), .oresp(oresp),
        .grant_valid(gv_rr), .grant_idx(gi_rr), .timeout(to_rr), .abort(ab_rr)
    );

    cbus_rr_arbiter #(.NUM_INPUTS(4), .RR_MODE(0), .TIMEOUT(8)) dut_fp (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps_fp), .oreq(oreq_fp), .oresp(oresp),
        .grant_valid(gv_fp), .grant_idx(gi_fp), .timeout(to_fp), .abort(ab_fp)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic drop_all();
        for (int i = 0; i < 4; i++) ireqs[i].valid = 1'b0;
        oresp = '0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ireqs[i] = '0;
            ireqs[i].addr = 32'(i + 1) << 12;
            ireqs[i].wdata = 32'hC0DE_0000 + 32'(i);
        end
        oresp = '0;
        cyc();
        cyc();
        check_b("rst_gv", gv_rr, 1'b0);
        check("rst_gi", 66'(gi_rr), 66'(0));
        check("rst_oreq", 66'(oreq_rr), 66'(0));
        check_b("rst_to", to_rr, 1'b0);
        check_b("rst_ab", ab_rr, 1'b0);
        check("rst_iresp2", 66'(iresps_rr[2]), 66'(0));
        reset = 1'b0;

        ireqs[2].valid = 1'b1;
        cyc();
        check("mid_gi", 66'(gi_rr), 66'(2));
        check("mid_oreq", 66'(oreq_rr), 66'(ireqs[2]));
        reset = 1'b1;
        ireqs[2].valid = 1'b0;
        cyc();
        check_b("mid_rst_gv", gv_rr, 1'b0);
        check_b("mid_rst_oreq_v", oreq_rr.valid, 1'b0);
        check_b("mid_rst_to", to_rr, 1'b0);
        check_b("mid_rst_ab", ab_rr, 1'b0);
        check("mid_rst_ptr", 66'(dut_rr.rr_ptr_q), 66'(0));
        reset = 1'b0;
        cyc();
        check_b("mid_post_to", to_rr, 1'b0);
        check_b("mid_post_ab", ab_rr, 1'b0);

        ireqs[0].valid = 1'b1;
        ireqs[1].valid = 1'b1;
        ireqs[3].valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            cyc();
            check("rr_gi", 66'(gi_rr), 66'(rr_order[n]));
            check_b("rr_gv_c0", gv_rr, 1'b1);
            oresp = '{ready: 1'b1, last: 1'b1, rdata: 32'h5A00 + 32'(n)};
            #1;
            check_b("rr_gv_c1", gv_rr, 1'b1);
            check("rr_iresp", 66'(iresps_rr[rr_order[n]]), 66'(oresp));
            cyc();
            oresp = '0;
            #1;
            check_b("rr_idle_gv", gv_rr, 1'b0);
            check_b("rr_idle_ab", ab_rr, 1'b0);
        end
        drop_all();
        reset = 1'b1;
        cyc();
        reset = 1'b0;

        ireqs[1].valid = 1'b1;
        ireqs[3].valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            check("fp_gi", 66'(gi_fp), 66'(1));
            check("fp_iresp3_c0", 66'(iresps_fp[3]), 66'(0));
            oresp = '{ready: 1'b1, last: 1'b1, rdata: 32'hF00D};
            #1;
            check("fp_iresp1", 66'(iresps_fp[1]), 66'(oresp));
            check("fp_iresp3_c1", 66'(iresps_fp[3]), 66'(0));
            cyc();
            oresp = '0;
            #1;
            check_b("fp_idle_gv", gv_fp, 1'b0);
        end
        drop_all();
        reset = 1'b1;
        cyc();
        reset = 1'b0;

        ireqs[2].valid = 1'b1;
        cyc();
        for (int b = 1; b <= 4; b++) begin
            oresp = '{ready: 1'b1, last: (b == 4), rdata: 32'h11 * 32'(b)};
            #1;
            check("burst_iresp2", 66'(iresps_rr[2]), 66'(oresp));
            check("burst_iresp1", 66'(iresps_rr[1]), 66'(0));
            check("burst_oreq", 66'(oreq_rr), 66'(ireqs[2]));
            cyc();
        end
        drop_all();
        #1;
        check_b("burst_end_gv", gv_rr, 1'b0);
        check("burst_end_ptr", 66'(dut_rr.rr_ptr_q), 66'(3));
        check_b("burst_end_ab", ab_rr, 1'b0);

        ireqs[1].valid = 1'b1;
        ireqs[2].valid = 1'b1;
        cyc();
        check("to_gi", 66'(gi_rr), 66'(1));
        for (int c = 1; c < 8; c++) begin
            cyc();
            check_b("to_wait_gv", gv_rr, 1'b1);
            check_b("to_wait_to", to_rr, 1'b0);
        end
        cyc();
        check_b("to_pulse", to_rr, 1'b1);
        check_b("to_pulse_gv", gv_rr, 1'b0);
        check_b("to_pulse_ab", ab_rr, 1'b0);
        cyc();
        check_b("to_pulse_end", to_rr, 1'b0);
        check_b("to_next_gv", gv_rr, 1'b1);
        check("to_next_gi", 66'(gi_rr), 66'(2));
        ireqs[1].valid = 1'b0;
        oresp = '{ready: 1'b1, last: 1'b1, rdata: 32'h0};
        cyc();
        check_b("to_done_gv", gv_rr, 1'b0);
        check_b("to_done_ab", ab_rr, 1'b0);
        drop_all();
        reset = 1'b1;
        cyc();
        reset = 1'b0;

        ireqs[0].valid = 1'b1;
        cyc();
        cyc();
        cyc();
        ireqs[0].valid = 1'b0;
        #1;
        check_b("ab_pre_gv", gv_rr, 1'b1);
        check_b("ab_pre_ab", ab_rr, 1'b0);
        check_b("ab_live_oreq_v", oreq_rr.valid, 1'b0);
        cyc();
        check_b("ab_pulse", ab_rr, 1'b1);
        check_b("ab_pulse_gv", gv_rr, 1'b0);
        check_b("ab_pulse_to", to_rr, 1'b0);
        cyc();
        check_b("ab_pulse_end", ab_rr, 1'b0);
        check("ab_ptr", 66'(dut_rr.rr_ptr_q), 66'(1));

        ireqs[0].valid = 1'b1;
        cyc();
        check("ab2_gi", 66'(gi_rr), 66'(0));
        cyc();
        cyc();
        ireqs[0].valid = 1'b0;
        oresp = '{ready: 1'b1, last: 1'b1, rdata: 32'hBEEF};
        cyc();
        check_b("ab2_no_ab", ab_rr, 1'b0);
        check_b("ab2_no_to", to_rr, 1'b0);
        check_b("ab2_gv", gv_rr, 1'b0);
        check("ab2_ptr", 66'(dut_rr.rr_ptr_q), 66'(1));
        drop_all();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- N-to-1 arbiter for the cache bus (cbus_req_t / cbus_resp_t from package common).
- Multiplexes several requesters (fetch, data, page-table walker, DMA) onto one downstream cbus port. The port feeds the MMU or the memory interconnect.
- Supports fixed-priority or round-robin selection.
- Adds a per-transaction timeout watchdog and detection of requests withdrawn mid-transaction.
- Reports the current grant for debug and performance monitoring.

Parameters:
- NUM_INPUTS, 4, number of requesters; must be >= 1.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- TIMEOUT, 1024, max consecutive busy cycles with oresp.ready low before forced release; 0 disables the watchdog.
- IDX_W, max(1, $clog2(NUM_INPUTS)), width of index signals (localparam).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ireqs  input  NUM_INPUTS x cbus_req_t  requester requests.
- iresps  output  NUM_INPUTS x cbus_resp_t  responses to requesters.
- oreq  output  cbus_req_t  request to the downstream port.
- oresp  input  cbus_resp_t  downstream response.
- grant_valid  output  1  a transaction is currently owned.
- grant_idx  output  IDX_W  owning requester; 0 when grant_valid = 0.
- timeout  output  1  one-cycle pulse on watchdog release.
- abort  output  1  one-cycle pulse when the owner drops valid before last.

Behaviour:
- Only one clock and one reset. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE, index = 0, rr_ptr = 0, wd_cnt = 0.
  - oreq = '0, iresps = '0, grant_valid = 0, grant_idx = 0, timeout = 0, abort = 0.
- A reset asserted mid-transaction drops ownership immediately. No pulse is generated.
- States: IDLE and BUSY.
- Selection (combinational, evaluated in IDLE):
  - RR_MODE = 1: first valid index scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_INPUTS.
  - RR_MODE = 0: lowest valid index.
- IDLE -> BUSY: if any ireqs[i].valid at edge t, then state = BUSY and index = select from t+1. The one-cycle grant latency is intentional.
- In IDLE:
  - oreq = '0 and all iresps = '0.
  - No request is issued downstream before grant.
- In BUSY:
  - oreq = ireqs[index], live, not latched.
  - iresps[index] = oresp; all other iresps = '0.
  - grant_valid = 1, grant_idx = index.
- BUSY -> IDLE on oresp.last:
  - Transition occurs at the next edge.
  - If RR_MODE = 1, rr_ptr = (index+1) mod NUM_INPUTS, wrapping N-1 -> 0.
  - At least one IDLE cycle separates consecutive grants.
- Abort:
  - Trigger: in BUSY, ireqs[index].valid = 0 and oresp.last = 0.
  - Effect: next edge goes to IDLE, abort = 1 for one cycle, rr_ptr advances as on completion.
- Watchdog (TIMEOUT > 0):
  - wd_cnt clears on entering BUSY and on every cycle with oresp.ready = 1.
  - wd_cnt increments otherwise.
  - When wd_cnt == TIMEOUT-1 and ready = 0: next edge goes to IDLE, timeout = 1 for one cycle, rr_ptr advances.
  - wd_cnt saturates and never wraps.
- Priority of simultaneous events: oresp.last > abort > timeout. Only one pulse is ever asserted per cycle.
- Requests on non-owner ports are ignored and receive zero responses until granted. Requesters must hold valid and fields stable until last.
- NUM_INPUTS = 1: behaves as the 2-state pass-through; rr_ptr stays 0.

Optional Feature:
- Macro CBUS_ARB_BYPASS_EN.
- Defined (zero-latency idle grant):
  - In IDLE with a valid request, oreq = ireqs[select] and iresps[select] = oresp in the same cycle. grant_valid = 1 and grant_idx = select combinationally.
  - If oresp.last is also 1 that cycle, the transaction completes: state stays IDLE and rr_ptr advances.
  - Otherwise state becomes BUSY with index = select at the next edge.
  - The watchdog counts from the bypass cycle.
- Undefined: the one-cycle grant latency described above applies; no combinational path from ireqs.valid to oreq.valid in IDLE.

Test Plan:
- Reset mid-BUSY (NUM_INPUTS = 4, port 2 owning) -> next cycle grant_valid = 0, oreq.valid = 0, no timeout/abort pulse, rr_ptr = 0.
- RR_MODE = 1, ports 0, 1 and 3 hold valid, each single beat (ready = last = 1 one cycle after grant) -> grant order 0, 1, 3, 0, 1, 3. Each grant_valid high for exactly 2 cycles (grant cycle plus response cycle), with 1 IDLE cycle between grants.
- RR_MODE = 0, ports 1 and 3 valid continuously -> port 1 granted every time; iresps[3] stays '0 throughout.
- Burst of 4 beats on port 2 -> iresps[2] mirrors oresp for 4 ready beats, last on beat 4. Next cycle IDLE, rr_ptr = 3.
- TIMEOUT = 8, oresp.ready held 0 after granting port 1 -> timeout pulses exactly 8 cycles after grant; state returns to IDLE; port 2 granted next if valid.
- Port 0 drops valid on the 3rd BUSY cycle with last = 0 -> abort pulses once, grant_valid = 0 the next cycle. Repeating with last = 1 in the same cycle -> no abort, normal completion.
